ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_clk_filter.sv | 37 +++
 rtl/ps2_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: the transmitter state encoding, the default line
// timing constants and the odd-parity helper. Used by the host transmitter
// and the receiver path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    ACK   = 3'd5,
    REL   = 3'd6
  } ps2_tx_state_t;

  // 100 us clock inhibit and 20 ms device-response watchdog at 50 MHz
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 1000000;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher and falling-edge strobe. The filtered level only
// moves once eight consecutive samples agree; fall is a one-cycle strobe on
// a filtered 1->0 transition. The line idles high, so reset presets to 1.
module ps2_clk_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_in,
  output logic f_ps2c,
  output logic fall
);

  logic [7:0] shift_q;
  logic       f_next;

  // sample history and filtered level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 8'hFF;
      f_ps2c  <= 1'b1;
    end else begin
      shift_q <= {ps2c_in, shift_q[7:1]};
      f_ps2c  <= f_next;
    end
  end

  // hold the filtered value unless the whole history agrees
  always_comb begin
    f_next = f_ps2c;
    if (shift_q == 8'hFF)
      f_next = 1'b1;
    else if (shift_q == 8'h00)
      f_next = 1'b0;
  end

  assign fall = f_ps2c & ~f_next;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. Inhibits the clock, issues the start bit,
// shifts 8 data bits LSB first plus odd parity on device clock falls, sends
// the stop bit, samples the device ACK and waits for the bus to go idle.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts the
// transfer with tx_err=1 if the device stops clocking.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_t    state_q, state_d;
  logic [INH_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nbit_q, nbit_d;
  logic [8:0]       bits_q, bits_d;
  logic             nack_q, nack_d;
  logic             c_oe_d, d_oe_d, idle_d, done_d, err_d;
  logic             f_ps2c, fall;
  logic             timeout_hit;

  ps2_clk_filter u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2c_in (ps2c_in),
    .f_ps2c  (f_ps2c),
    .fall    (fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // watchdog: restarts on every device clock fall while the device owns the clock
  always_comb begin
    wd_d = '0;
    if (state_q == START || state_q == DATA || state_q == STOP ||
        state_q == ACK || state_q == REL)
      wd_d = fall ? '0 : wd_q + 1'b1;
  end

  // watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign timeout_hit = (wd_q == WD_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // next state, counters and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    bits_d  = bits_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          bits_d  = {odd_parity(din), din};
          cnt_d   = INH_W'(INHIBIT_CYCLES - 1);
          nack_d  = 1'b0;
          state_d = RTS;
        end
      end
      RTS: begin
        if (cnt_q == '0) state_d = START;
        else             cnt_d   = cnt_q - 1'b1;
      end
      START: begin
        if (fall) begin
          nbit_d  = 4'd8;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          bits_d = {1'b0, bits_q[8:1]};
          if (nbit_q == 4'd0) state_d = STOP;
          else                nbit_d  = nbit_q - 1'b1;
        end
      end
      STOP: begin
        if (fall) state_d = ACK;
      end
      ACK: begin
        if (fall) begin
          nack_d  = ps2d_in;
          state_d = REL;
        end
      end
      REL: begin
        if (f_ps2c && ps2d_in) begin
          done_d  = 1'b1;
          err_d   = nack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = IDLE;
    end
    // outputs follow the state being entered so they come straight from flops
    c_oe_d = (state_d == RTS);
    d_oe_d = (state_d == START) || ((state_d == DATA) && !bits_d[0]);
    idle_d = (state_d == IDLE);
  end

  // control state and registered line drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nbit_q       <= '0;
      nack_q       <= 1'b0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbit_q       <= nbit_d;
      nack_q       <= nack_d;
      ps2c_oe      <= c_oe_d;
      ps2d_oe      <= d_oe_d;
      tx_idle      <= idle_d;
      tx_done_tick <= done_d;
      tx_err       <= err_d;
    end
  end

  // frame shift register (data path, not reset)
  always_ff @(posedge clk) begin
    bits_q <= bits_d;
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a PS/2 device model clocks frames out of the
// host, records the bit seen on the data line before each falling clock and
// answers with ACK or NACK. Expected frames are hand-computed constants.
module tb_ps2_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic done_err = 1'b0;

  // open-drain bus: either side may pull low
  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  ps2_tx #(.INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(2000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done_tick) begin
      done_cnt = done_cnt + 1;
      done_err = tx_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one host transfer; inject_clk pulses wr_ps2 during that device clock,
  // reset_clk asserts rst_n during that device clock and abandons the frame
  task automatic send(input string tag, input logic [7:0] d, input logic [10:0] exp_frame,
                      input logic ack, input logic exp_err,
                      input int inject_clk, input int reset_clk);
    int n;
    int d0;
    logic [10:0] frame;
    d0 = done_cnt;
    frame = '0;
    @(posedge clk); #1;
    din = d; wr_ps2 = 1'b1;
    @(posedge clk); #1;
    wr_ps2 = 1'b0;
    chk({tag, "_rts_clk_low"}, ps2c_oe, 1'b1);
    chk({tag, "_busy"}, tx_idle, 1'b0);
    n = 0;
    while (!ps2d_oe && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_inhibit_len"}, n, 5000);
    chk({tag, "_clk_released"}, ps2c_oe, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k == 11) dev_d = ack ? 1'b0 : 1'b1;
      repeat (20) @(posedge clk);
      #1;
      if (k < 11) frame[k] = ps2d_in;
      if (k == inject_clk) begin
        din = ~d; wr_ps2 = 1'b1;
        @(posedge clk); #1;
        wr_ps2 = 1'b0; din = d;
      end
      if (k == reset_clk) begin
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_c_oe"}, ps2c_oe, 1'b0);
        chk({tag, "_rst_d_oe"}, ps2d_oe, 1'b0);
        chk({tag, "_rst_idle"}, tx_idle, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk({tag, "_rst_no_done"}, done_cnt - d0, 0);
        chk({tag, "_rst_lines"}, {ps2c_oe, ps2d_oe}, 2'b00);
        return;
      end
      dev_c = 1'b0;
      repeat (20) @(posedge clk);
      #1 dev_c = 1'b1;
    end
    dev_d = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
    chk({tag, "_err"}, done_err, exp_err);
    chk({tag, "_frame"}, frame, exp_frame);
    repeat (30) @(posedge clk);
    #1;
    chk({tag, "_idle_after"}, tx_idle, 1'b1);
    chk({tag, "_single_done"}, done_cnt - d0, 1);
    chk({tag, "_lines_after"}, {ps2c_oe, ps2d_oe}, 2'b00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_c_oe", ps2c_oe, 1'b0);
    chk("reset_d_oe", ps2d_oe, 1'b0);
    chk("reset_idle", tx_idle, 1'b1);
    chk("reset_done", tx_done_tick, 1'b0);
    chk("reset_err", tx_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // frame bits [0]=start [8:1]=data LSB first [9]=parity [10]=stop
    send("ed_ack",  8'hED, 11'h7DA, 1'b1, 1'b0, -1, -1);
    send("f4_ack",  8'hF4, 11'h5E8, 1'b1, 1'b0, -1, -1);
    send("ff_ack",  8'hFF, 11'h7FE, 1'b1, 1'b0, -1, -1);
    send("a5_nack", 8'hA5, 11'h74A, 1'b0, 1'b1, -1, -1);
    send("00_wr_in_data", 8'h00, 11'h600, 1'b1, 1'b0, 4, -1);
    send("3c_reset", 8'h3C, 11'h000, 1'b1, 1'b0, -1, 5);
    send("ed_after_rst", 8'hED, 11'h7DA, 1'b1, 1'b0, -1, -1);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      din = 8'h55; wr_ps2 = 1'b1;
      @(posedge clk); #1;
      wr_ps2 = 1'b0;
      repeat (5001) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        repeat (20) @(posedge clk);
        #1 dev_c = 1'b0;
        repeat (20) @(posedge clk);
        #1 dev_c = 1'b1;
      end
      n = 0;
      while (done_cnt == d0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("wd_done", done_cnt - d0, 1);
      chk("wd_err", done_err, 1'b1);
      #1;
      chk("wd_lines", {ps2c_oe, ps2d_oe}, 2'b00);
      chk("wd_idle", tx_idle, 1'b1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
